// File: rtl/msix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msix_pkg
// Description : Shared types and constants for the MSI-X message generator.
// Revision    : 1.0 - initial release
// ============================================================================
package msix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SEND  = 2'd3
    } msix_state_e;

    // MSI-X table Vector Control dword with the TPH steering-tag extension
    typedef struct packed {
        logic [7:0]  st_upper;
        logic [7:0]  st_lower;
        logic [14:0] reserved;
        logic        mask_bit;
    } msix_vec_ctrl_t;

    localparam logic [1:0] ST_LOC_MSIX_TABLE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/msix_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : msix_rr_arbiter
// Description : Combinational round-robin pick of the first set request at or
//               after ptr, wrapping modulo NUM_VECTORS.
// Revision    : 1.0 - initial release
// ============================================================================
module msix_rr_arbiter #(
    parameter int NUM_VECTORS = 8,
    parameter int IDX_W       = $clog2(NUM_VECTORS)
) (
    input  logic [NUM_VECTORS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   grant_valid
);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_VECTORS - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % NUM_VECTORS;
            if (req[j]) begin
                grant_idx   = IDX_W'(j);
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/msix_message_generator.sv
`default_nettype none
// ============================================================================
// Module      : msix_message_generator
// Description : Pending-bit tracking, table lookup and memory-write request
//               generation for MSI-X. Macro MSIX_TPH_EN enables steering tags.
// Revision    : 1.0 - initial release
// ============================================================================
module msix_message_generator
    import msix_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    parameter int IDX_W       = $clog2(NUM_VECTORS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   msix_enable,
    input  logic                   function_mask,
    input  logic [NUM_VECTORS-1:0] irq_req,
    output logic                   tbl_rd_en,
    output logic [IDX_W-1:0]       tbl_rd_idx,
    input  logic [63:0]            tbl_addr,
    input  logic [31:0]            tbl_data,
    input  logic [31:0]            tbl_vec_ctrl,
    input  logic                   tph_requester_enable,
    input  logic [1:0]             st_table_location,
    input  logic                   extended_tph_requester_supported,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [63:0]            tx_addr,
    output logic [31:0]            tx_data,
    output logic [15:0]            tx_st,
    output logic                   tx_th,
    output logic [NUM_VECTORS-1:0] pba,
    output logic                   busy
);

    msix_state_e            state_q;
    logic [NUM_VECTORS-1:0] pba_q, pba_d;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       w_idx_next;
    logic                   tbl_rd_en_q;
    logic [IDX_W-1:0]       tbl_rd_idx_q;
    logic                   tx_valid_q;
    logic [63:0]            tx_addr_q;
    logic [31:0]            tx_data_q;
    logic [15:0]            tx_st_q;
    logic                   tx_th_q;

    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_handshake;
    msix_vec_ctrl_t         w_vc;
    logic [15:0]            w_st;
    logic                   w_th;
    logic                   w_unused;

    msix_rr_arbiter #(
        .NUM_VECTORS (NUM_VECTORS),
        .IDX_W       (IDX_W)
    ) u_arb (
        .req         (pba_q),
        .ptr         (rr_ptr_q),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign w_vc        = msix_vec_ctrl_t'(tbl_vec_ctrl);
    assign w_handshake = (state_q == ST_SEND) && tx_ready;
    assign w_idx_next  = (idx_q == IDX_W'(NUM_VECTORS - 1)) ? '0 : idx_q + 1'b1;

`ifdef MSIX_TPH_EN
    always_comb begin
        w_st = '0;
        w_th = 1'b0;
        if (tph_requester_enable && (st_table_location == ST_LOC_MSIX_TABLE)) begin
            w_th      = 1'b1;
            w_st[7:0] = w_vc.st_lower;
            if (extended_tph_requester_supported) begin
                w_st[15:8] = w_vc.st_upper;
            end
        end
    end
    assign w_unused = &{1'b0, w_vc.reserved, tbl_addr[1:0]};
`else
    assign w_st     = '0;
    assign w_th     = 1'b0;
    assign w_unused = &{1'b0, w_vc.reserved, w_vc.st_upper, w_vc.st_lower, tbl_addr[1:0],
                        tph_requester_enable, st_table_location,
                        extended_tph_requester_supported};
`endif

    // A new event on the vector being retired keeps its pending bit set
    always_comb begin
        pba_d = pba_q;
        if (w_handshake) begin
            pba_d[idx_q] = 1'b0;
        end
        if (msix_enable) begin
            pba_d = pba_d | irq_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pba_q        <= '0;
            rr_ptr_q     <= '0;
            idx_q        <= '0;
            tbl_rd_en_q  <= 1'b0;
            tbl_rd_idx_q <= '0;
            tx_valid_q   <= 1'b0;
            tx_addr_q    <= '0;
            tx_data_q    <= '0;
            tx_st_q      <= '0;
            tx_th_q      <= 1'b0;
        end else begin
            pba_q       <= pba_d;
            tbl_rd_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (msix_enable && w_grant_valid) begin
                        idx_q        <= w_grant_idx;
                        tbl_rd_en_q  <= 1'b1;
                        tbl_rd_idx_q <= w_grant_idx;
                        state_q      <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    // Masked vectors stay pending and yield to the next vector
                    if (w_vc.mask_bit || function_mask) begin
                        rr_ptr_q <= w_idx_next;
                        state_q  <= ST_IDLE;
                    end else begin
                        tx_addr_q  <= {tbl_addr[63:2], 2'b00};
                        tx_data_q  <= tbl_data;
                        tx_st_q    <= w_st;
                        tx_th_q    <= w_th;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        rr_ptr_q   <= w_idx_next;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tbl_rd_en  = tbl_rd_en_q;
    assign tbl_rd_idx = tbl_rd_idx_q;
    assign tx_valid   = tx_valid_q;
    assign tx_addr    = tx_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_st      = tx_st_q;
    assign tx_th      = tx_th_q;
    assign pba        = pba_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/msix_message_generator.md
MSIX_MESSAGE_GENERATOR -- requirements
Module: msix_message_generator

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 8, number of MSI-X table entries (2..64).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_VECTORS), vector index width.
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- msix_enable in 1: MSI-X Enable.
- function_mask in 1: Function Mask.
- irq_req in NUM_VECTORS: per-vector interrupt event, 1-cycle pulse.
- tbl_rd_en out 1: table read strobe.
- tbl_rd_idx out IDX_W: table read index.
- tbl_addr in 64: entry Message Address, valid 1 cycle after tbl_rd_en.
- tbl_data in 32: entry Message Data, same timing.
- tbl_vec_ctrl in 32: entry Vector Control, same timing.
- tph_requester_enable in 1: TPH Requester Enable.
- st_table_location in 2: ST Table Location.
- extended_tph_requester_supported in 1: Extended TPH capable.
- tx_valid out 1: message request valid.
- tx_ready in 1: transmitter accept.
- tx_addr out 64, tx_data out 32: memory-write address and payload.
- tx_st out 16: Steering Tag {upper, lower}.
- tx_th out 1: TPH present.
- pba out NUM_VECTORS: Pending Bit Array.
- busy out 1: FSM not IDLE.

Function
REQ-004 SHALL set pba[i] on irq_req[i] when msix_enable=1; irq_req ignored when msix_enable=0.
REQ-005 SHALL use FSM IDLE->READ->CHECK->SEND->IDLE; CHECK may return directly to IDLE.
REQ-006 IDLE: if msix_enable=1 and pba!=0, SHALL pick a pending vector round-robin starting at rr_ptr, drive tbl_rd_en=1 and tbl_rd_idx for exactly that cycle, go READ.
REQ-007 READ: SHALL wait one cycle for table data, go CHECK.
REQ-008 CHECK: if tbl_vec_ctrl[0]=1 or function_mask=1, SHALL leave pba set, set rr_ptr=idx+1 (mod NUM_VECTORS), go IDLE.
REQ-009 CHECK, unmasked: SHALL register tx_addr={tbl_addr[63:2],2'b00}, tx_data=tbl_data, ST fields, go SEND.
REQ-010 SEND: SHALL hold tx_valid=1 with all tx_* stable until tx_ready=1; on handshake clear pba[idx], set rr_ptr=idx+1, go IDLE.
REQ-011 Same-cycle set (irq_req) and clear (handshake) of one pba bit SHALL leave it set.
REQ-012 msix_enable or function_mask change during SEND SHALL NOT abort the in-flight message.
REQ-013 Latency SHALL be 3 cycles from IDLE selection to tx_valid rise (IDLE, READ, CHECK; tx_valid in 4th).
REQ-014 tx_st/tx_th: if tph_requester_enable=1 and st_table_location=2'b10, tx_th=1, tx_st[7:0]=tbl_vec_ctrl[23:16], tx_st[15:8]=tbl_vec_ctrl[31:24] when extended_tph_requester_supported=1 else 0; otherwise tx_st=0, tx_th=0.
REQ-015 busy SHALL be 1 in READ, CHECK, SEND.

Reset
REQ-016 rst_n low SHALL asynchronously force FSM=IDLE, pba=0, rr_ptr=0, tx_valid=0, tx_addr=0, tx_data=0, tx_st=0, tx_th=0, tbl_rd_en=0, tbl_rd_idx=0, busy=0.
REQ-017 Reset during SEND SHALL drop tx_valid immediately; the message is lost.

Configuration
REQ-018 Macro MSIX_TPH_EN: defined -> REQ-014 behaviour; undefined -> tx_st=0, tx_th=0 constantly and the three TPH inputs are unused.

Structure
REQ-019 Package msix_pkg SHALL hold the FSM state enum, the Vector Control packed struct (st_upper, st_lower, reserved, mask_bit), and constant ST_LOC_MSIX_TABLE=2'b10.
REQ-020 Round-robin selection SHALL be sub-module msix_rr_arbiter (inputs req, ptr; outputs grant_idx, grant_valid).

Verification
REQ-021 irq_req[3] pulse, vec_ctrl=0, addr=64'hFEE0_0000_0000_1003, data=32'h41, tx_ready=1 -> tx_valid 4 cycles later, tx_addr=...1000, tx_data=32'h41, pba[3] cleared.
REQ-022 Vector 2 masked (vec_ctrl[0]=1), irq_req[2] -> no tx_valid, pba[2] stays 1; clear mask, next pass sends, pba[2]=0.
REQ-023 irq_req=8'hFF, all unmasked -> messages in order 0..7, none repeated, pba=0 at end.
REQ-024 tx_ready low 10 cycles in SEND, irq_req to same vector on handshake cycle -> tx_* stable throughout, pba bit remains 1, second message follows.
REQ-025 TPH on, st_loc=2'b10, vec_ctrl=32'hAB_CD_0000, extended=0 -> tx_st=16'h00CD, tx_th=1; extended=1 -> 16'hABCD; MSIX_TPH_EN undefined -> 0.
REQ-026 rst_n asserted mid-SEND -> all outputs zero same cycle; msix_enable=0 with irq_req -> pba unchanged.
